// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX constants and the fetch buffer entry type
package dlx_pkg;
  localparam int XLEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous FIFO with flush, count and same-cycle push/pop
module ifetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/sram.sv
// sram: word-addressed memory with combinational read and clocked write
module sram #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter string mem_file = ""
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          oe,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];
  if (mem_file == "") begin : g_blank_image
  end
  always_ff @(posedge clk) begin
    if (cs && we) mem[addr] <= din;
  end
  assign dout = (cs && oe) ? mem[addr] : '0;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: DLX fetch stage owning the PC, the instruction sram and a fetch buffer
module ifetch_unit #(
  parameter int XLEN = dlx_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(dlx_pkg::RESET_PC),
  parameter int PC_STEP = dlx_pkg::PC_STEP,
  parameter int ADDR_SHIFT = 2,
  parameter string MEM_FILE = "data/unsigned_sum.dat"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);
  localparam int AW = 10;
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] fetch_pc, sram_dout;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0] count;
  logic push, pop;
  sram #(.AW(AW), .DW(XLEN), .mem_file(MEM_FILE)) u_sram (
    .clk(clk),
    .cs(1'b1),
    .oe(1'b1),
    .we(1'b0),
    .addr(fetch_pc[ADDR_SHIFT +: AW]),
    .din({XLEN{1'b0}}),
    .dout(sram_dout)
  );
  ifetch_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .din({fetch_pc, sram_dout}),
    .dout(head),
    .count(count)
  );
  always_comb begin
    out_valid = (count != '0) && !redirect_valid;
    pop = out_valid && out_ready;
    push = fetch_en && !redirect_valid && ((count < CW'(DEPTH)) || pop);
    out_pc = out_valid ? head[2*XLEN-1:XLEN] : '0;
    out_instr = out_valid ? head[XLEN-1:0] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc;
    else if (push) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed vector table plus randomized run against a queue model
module tb_ifetch_unit;
  import dlx_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [31:0] I0 = 32'h1000_0000;
  typedef struct {
    logic r, en, rv;
    logic [31:0] rpc;
    logic rdy;
    int mode;
    logic ev;
    logic [31:0] epc, ei;
  } vec_t;
  logic clk = 0;
  logic reset = 1, fetch_en = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0;
  logic out_valid;
  logic [31:0] out_pc, out_instr;
  int checks = 0, failures = 0;
  fetch_entry_t q[$];
  logic [31:0] mpc = 0;
  vec_t tbl[$];
  ifetch_unit dut (
    .clk(clk),
    .reset(reset),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_instr(out_instr)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] img(input logic [31:0] pc);
    return I0 + ((pc >> 2) & 32'h3FF);
  endfunction
  function automatic vec_t mk(input bit r, en, rv, input logic [31:0] rpc, input bit rdy,
                              input int mode, input bit ev, input logic [31:0] epc, ei);
    vec_t v;
    v.r = r; v.en = en; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.mode = mode; v.ev = ev; v.epc = epc; v.ei = ei;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [64:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got v=%0b pc=%h instr=%h expected v=%0b pc=%h instr=%h",
               nm, $time, act[64], act[63:32], act[31:0], exp[64], exp[63:32], exp[31:0]);
    end
  endtask
  task automatic cyc(input vec_t v);
    logic mv, pop, push;
    reset = v.r; fetch_en = v.en; redirect_valid = v.rv; redirect_pc = v.rpc; out_ready = v.rdy;
    @(negedge clk);
    mv = (q.size() != 0) && !v.rv;
    if (v.mode > 0)
      chk("model", {out_valid, out_pc, out_instr},
          {mv, mv ? q[0].pc : 32'h0, mv ? q[0].instr : 32'h0});
    if (v.mode > 1)
      chk("table", {out_valid, out_pc, out_instr}, {v.ev, v.epc, v.ei});
    if (v.r) begin
      q.delete();
      mpc = 32'h0;
    end else if (v.rv) begin
      q.delete();
      mpc = v.rpc;
    end else begin
      pop = mv && v.rdy;
      push = v.en && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: mpc, instr: img(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 1024; i++) dut.u_sram.mem[i] = I0 + i;
    tbl.push_back(mk(1,1,0,0,1,0, 0,0,0));
    tbl.push_back(mk(1,1,0,0,0,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,2, 0,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,0,0,0,2, 1,0,I0));
    tbl.push_back(mk(0,1,0,0,1,2, 1,0,I0));
    tbl.push_back(mk(0,1,0,0,0,2, 1,32'h4,I0+1));
    tbl.push_back(mk(0,1,0,0,1,2, 1,32'h4,I0+1));
    for (int i = 2; i < 7; i++) tbl.push_back(mk(0,1,0,0,1,2, 1,32'(4*i),I0+32'(i)));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,2, 1,0,I0));
    tbl.push_back(mk(0,1,0,0,0,2, 1,0,I0));
    tbl.push_back(mk(0,1,1,32'h40,0,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,1,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,1,2, 1,32'h40,I0+16));
    tbl.push_back(mk(0,1,0,0,1,2, 1,32'h44,I0+17));
    tbl.push_back(mk(1,1,1,32'h80,1,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,1,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,1,2, 1,0,I0));
    tbl.push_back(mk(0,1,0,0,0,2, 1,32'h4,I0+1));
    tbl.push_back(mk(0,0,0,0,1,2, 1,32'h4,I0+1));
    tbl.push_back(mk(0,0,0,0,1,2, 1,32'h8,I0+2));
    tbl.push_back(mk(0,0,0,0,1,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,1,2, 0,0,0));
    tbl.push_back(mk(0,1,0,0,1,2, 1,32'hC,I0+3));
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc(mk($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 2) != 0, 1, 0, 0, 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
